// File: rtl/mystery2_pkg.sv
// rtl/mystery2_pkg.sv - shared types and permutation helpers for the descrambler
//
// Purpose: FSM state encoding plus the two word permutations used by the
// scrambler/descrambler pair. Both permutations are self-inverse, so the
// same functions serve the scrambler model and the receive-side inverse.
// Ports: none (package).
package mystery2_pkg;

  typedef enum logic [2:0] {
    S_WORD   = 3'd0,
    S_PAR    = 3'd1,
    S_UNNIB  = 3'd2,
    S_UNSWAP = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  // Reverse the order of the four nibbles.
  function automatic logic [15:0] nib_rev(input logic [15:0] w);
    return {w[3:0], w[7:4], w[11:8], w[15:12]};
  endfunction

  // Exchange the high and low bytes.
  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/mystery2_descrambler.sv
// rtl/mystery2_descrambler.sv - receive-side inverse of the 5-phase byte/nibble scrambler
//
// Purpose: accepts a 2-beat frame (scrambled word, then parity word {15'b0, p}),
// undoes the nibble reversal and then the byte swap one step per cycle, checks
// parity and padding, and presents the recovered {hi, lo} word with error flags.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_data/in_valid    input beat stream; in_ready high only in S_WORD/S_PAR
//   out_data/out_hi/lo  recovered word and its byte slices
//   out_err_parity      recovered word parity differs from the frame's p bit
//   out_err_pad         nonzero parity_word[15:1] (CHECK_PAD != 0 only)
//   out_valid/out_ready output handshake; outputs hold until out_ready
//   err_count           saturating count of frames with any error
module mystery2_descrambler
  import mystery2_pkg::*;
#(
  parameter int CHECK_PAD = 1,
  parameter int ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [15:0]         out_data,
  output logic [7:0]          out_hi,
  output logic [7:0]          out_lo,
  output logic                out_err_parity,
  output logic                out_err_pad,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ERRCNT_W-1:0] err_count
);

  state_t        state;
  state_t        state_nx;
  logic [15:0]   word_r;
  logic          p_r;
  logic          pad_r;
  logic [15:0]   unswapped;
  logic          parity_err;
  logic          pad_err;

  // Errors are evaluated on the value being written in S_UNSWAP; parity is
  // permutation-invariant so checking the recovered word is equivalent.
  assign unswapped  = byte_swap(word_r);
  assign parity_err = (^unswapped) != p_r;
  assign pad_err    = (CHECK_PAD != 0) && pad_r;

  assign out_hi = out_data[15:8];
  assign out_lo = out_data[7:0];

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      S_WORD: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_PAR;
      end
      S_PAR: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_UNNIB;
      end
      S_UNNIB:  state_nx = S_UNSWAP;
      S_UNSWAP: state_nx = S_OUT;
      S_OUT: begin
        if (out_ready) state_nx = S_WORD;
      end
      default:  state_nx = S_WORD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_WORD;
      word_r         <= 16'h0000;
      p_r            <= 1'b0;
      pad_r          <= 1'b0;
      out_data       <= 16'h0000;
      out_err_parity <= 1'b0;
      out_err_pad    <= 1'b0;
      out_valid      <= 1'b0;
      err_count      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_WORD: begin
          if (in_valid) word_r <= in_data;
        end
        S_PAR: begin
          if (in_valid) begin
            p_r   <= in_data[0];
            pad_r <= |in_data[15:1];
          end
        end
        S_UNNIB: begin
          word_r <= nib_rev(word_r);
        end
        S_UNSWAP: begin
          word_r         <= unswapped;
          out_data       <= unswapped;
          out_err_parity <= parity_err;
          out_err_pad    <= pad_err;
          out_valid      <= 1'b1;
          if ((parity_err || pad_err) && (err_count != {ERRCNT_W{1'b1}}))
            err_count <= err_count + 1'b1;
        end
        S_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mystery2_descrambler.md
Name: mystery2_descrambler

Overview:
- Receive-side inverse of the team's 5-phase byte/nibble scrambler sequencer.
- Accepts a 2-beat frame over a valid/ready stream:
  - beat 0: scrambled word, which is the byte-swapped then nibble-reversed image of the original {hi, lo} word;
  - beat 1: the parity word {15'b0, p}.
- Undoes the nibble reversal, then the byte swap, one transform per cycle. Checks parity and padding, and presents the recovered word with error flags on a valid/ready output.
- Sits between the scrambler's output bus and downstream consumers of the original {hi, lo} byte pair.

Parameters:
- CHECK_PAD, 1, when 1, a nonzero parity_word[15:1] sets err_pad; when 0, bits [15:1] are ignored.
- ERRCNT_W, 8, width of the saturating error-frame counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- in_data  input  16  frame beat (scrambled word, then parity word).
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a beat this cycle.
- out_data  output  16  recovered word {hi, lo}.
- out_hi  output  8  out_data[15:8].
- out_lo  output  8  out_data[7:0].
- out_err_parity  output  1  parity mismatch for this frame.
- out_err_pad  output  1  nonzero padding in the parity word (CHECK_PAD=1 only).
- out_valid  output  1  recovered frame available.
- out_ready  input  1  consumer accepts the frame.
- err_count  output  ERRCNT_W  number of frames with any error; saturates at all-ones.

Behaviour:
- Reset, checked before all else in the clocked block:
  - state = S_WORD;
  - the internal word register, out_data, both error flags and err_count = 0;
  - out_valid = 0; in_ready = 1 on the next cycle.
- Reset mid-frame or mid-output discards the frame. No output is produced for it and err_count is cleared.
- FSM:
  - S_WORD: in_ready=1. On in_valid, word_r <= in_data; go to S_PAR.
  - S_PAR: in_ready=1. On in_valid, latch the parity word (p_r <= in_data[0]; pad_r <= |in_data[15:1]); go to S_UNNIB.
  - S_UNNIB: in_ready=0. word_r <= {word_r[3:0], word_r[7:4], word_r[11:8], word_r[15:12]}; go to S_UNSWAP.
  - S_UNSWAP: in_ready=0. word_r <= {word_r[7:0], word_r[15:8]}.
    - Compute errors on the unswapped value: parity_err = (^unswapped) != p_r; pad_err = CHECK_PAD && pad_r.
    - Load out_data and both error flags; set out_valid=1; go to S_OUT.
    - If either error is set, err_count increments unless already saturated.
  - S_OUT: in_ready=0. out_valid, out_data and the error flags hold stable until out_ready=1.
    - On out_ready: out_valid <= 0; go to S_WORD.
- Latency:
  - parity beat accepted at edge N → out_valid=1 after edge N+2;
  - minimum frame period 5 cycles (2 input beats, 2 transforms, ≥1 output cycle).
- Outside S_WORD and S_PAR, in_valid is ignored (in_ready=0). The upstream must hold the beat.
- out_ready while out_valid=0 has no effect.
- Stalls: in_valid low in S_WORD or S_PAR waits indefinitely, with no timeout.
- Parity is the XOR reduction over all 16 bits. It is invariant under the permutations, so checking it on the recovered word is equivalent.
- out_hi and out_lo are combinational slices of out_data.

Decomposition:
- Package mystery2_pkg holds:
  - state enum (S_WORD, S_PAR, S_UNNIB, S_UNSWAP, S_OUT);
  - functions nib_rev(logic[15:0]) and byte_swap(logic[15:0]), each self-inverse, shared with the scrambler model in the bench.
- No sub-module; a single FSM plus a datapath register.

Test Plan:
- Basic frame: beats 0x2143 then 0x0001, out_ready=1 → out_data=0x1234, hi=0x12, lo=0x34, both errors 0, err_count=0; out_valid 2 cycles after the parity beat.
- Even-parity frame: beats 0x5A0F then 0x0000 → out_data=0xA5F0, no errors.
- Parity error: beats 0x2143 then 0x0000 → out_data=0x1234, err_parity=1, err_count=1.
- Pad error:
  - CHECK_PAD=1, beats 0x5A0F then 0x8000 → err_pad=1, err_parity=0, err_count increments;
  - same frame with CHECK_PAD=0 → no error.
- Backpressure: hold out_ready=0 for 10 cycles → out_data, flags and out_valid stable, in_ready=0 throughout. A beat offered with in_valid=1 during the stall is not consumed; it is accepted in S_WORD after out_ready=1.
- Reset mid-operation:
  - reset asserted in S_UNNIB → next cycle in_ready=1, out_valid=0, err_count=0, no output frame;
  - after ERRCNT_W=2 and 5 error frames → err_count saturates at 3.
